if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage of the pipelined CPU. Owns the PC register, drives the
//   address and read enable of the instruction memory, and captures the returned
//   instruction into the IF/ID pipeline register. Handles load-use stalls, branch and
//   jump redirects from ID/EX, halt, and fetches beyond the end of the instruction ROM.
// PARAMETERS
//   PC_RESET  32'h0000_0000  PC value loaded on reset
//   IM_BYTES  128            instruction ROM size in bytes; a PC >= IM_BYTES is out of range
// PORTS
//   clk           in   1   clock, rising edge
//   rstn          in   1   asynchronous active-low reset
//   stall         in   1   hazard unit: hold PC and IF/ID this cycle
//   redirect      in   1   taken branch/jump: load redirect_pc and squash IF/ID
//   redirect_pc   in   32  redirect target; bits [1:0] forced to 0
//   halt          in   1   stop fetching; the stage leaves HALT only on redirect or reset
//   instr         in   32  instruction word from the ROM (combinational read of pc)
//   pc            out  32  current fetch address, to the ROM
//   im_read_en    out  1   ROM read enable
//   ifid_instr    out  32  IF/ID instruction
//   ifid_pc4      out  32  IF/ID PC+4 of the captured instruction
//   ifid_valid    out  1   IF/ID holds a real instruction (0 = bubble)
//   fetch_fault   out  1   sticky: a fetch was attempted at PC >= IM_BYTES
// BEHAVIOUR
//   Reset (async, rstn=0): pc=PC_RESET, state=BOOT, ifid_instr=0, ifid_pc4=0,
//     ifid_valid=0, fetch_fault=0. Reset mid-operation aborts everything immediately.
//   States: BOOT, FETCH, HALT (2-bit register). im_read_en = (state==FETCH) && !oor,
//     where oor = (pc >= IM_BYTES). This output is combinational from the registers.
//   BOOT: one bubble cycle while the ROM finishes its reset init. Next state is FETCH.
//     pc holds and IF/ID stays a bubble. If redirect is asserted in BOOT, it loads pc and
//     the next state is still FETCH.
//   FETCH, evaluated in priority order each clock edge:
//     1 redirect: pc<=redirect_pc&~3; IF/ID<=bubble (instr 0, pc4 0, valid 0); stay FETCH
//     2 halt: pc holds; IF/ID<=bubble; ->HALT
//     3 oor: pc holds; IF/ID<=bubble; fetch_fault<=1; ->HALT
//     4 stall: pc, ifid_instr, ifid_pc4 and ifid_valid all hold
//     5 else: pc<=pc+4; ifid_instr<=instr; ifid_pc4<=pc+4; ifid_valid<=1
//   HALT: im_read_en=0; pc holds; IF/ID is a bubble; stall and halt are ignored.
//     redirect: pc<=redirect_pc&~3, fetch_fault<=0, ->FETCH.
//   Redirect beats stall: a branch resolved in the same cycle as a stall still squashes.
//   Fetch latency: the instruction at pc appears in ifid_instr 1 cycle after the edge
//     that sampled it. The first valid IF/ID appears on the 2nd edge after reset release.
//   Arithmetic: pc+4 is 32-bit unsigned and wraps 0xFFFF_FFFC -> 0 (oor catches this first
//     for any realistic IM_BYTES). pc[1:0] is always 0.
//   fetch_fault clears only on reset or on a redirect taken from HALT.
// TESTING
//   Reset release, no stimulus, ROM word0=0x2008_0005 -> edge1 BOOT; edge2 ifid_instr=
//     0x2008_0005, ifid_pc4=4, valid=1, pc=4; pc increments by 4 each following edge.
//   stall=1 for 2 cycles at pc=0x10 -> pc, ifid_* unchanged for 2 edges; resumes at 0x14.
//   redirect=1, redirect_pc=0x43, stall=1 same cycle -> pc=0x40, ifid_valid=0; the next
//     edge captures ROM[0x40], ifid_pc4=0x44.
//   Run to pc=0x80 with IM_BYTES=128 -> im_read_en=0, next edge fetch_fault=1, HALT, pc=0x80;
//     redirect to 0x0 -> fetch_fault=0, FETCH, pc=0.
//   halt=1 at pc=0x20 -> HALT, pc stays 0x20, im_read_en=0, valid=0 for 10 cycles despite stall
//     toggling; redirect_pc=0x8 -> resumes at 0x8.
//   rstn pulse low mid-stall at pc=0x30 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM, and fills the IF/ID register.
// Handles stall, redirect, halt and out-of-range fetches.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned IM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic        im_read_en,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_fault
);

    localparam logic [31:0] IM_LIMIT = 32'(IM_BYTES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        fault_q, fault_d;

    logic        oor;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign oor          = (pc_q >= IM_LIMIT);
    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = redirect_pc & ~32'd3;

    // Next-state and IF/ID update; every path holds unless it says otherwise.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fault_d      = fault_q;

        case (state_q)
            BOOT: begin
                state_d      = FETCH;
                ifid_instr_d = 32'd0;
                ifid_pc4_d   = 32'd0;
                ifid_valid_d = 1'b0;
                if (redirect) begin
                    pc_d = redirect_tgt;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_d         = redirect_tgt;
                    ifid_instr_d = 32'd0;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                end else if (halt) begin
                    state_d      = HALT;
                    ifid_instr_d = 32'd0;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                end else if (oor) begin
                    state_d      = HALT;
                    fault_d      = 1'b1;
                    ifid_instr_d = 32'd0;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d         = pc_plus4;
                    ifid_instr_d = instr;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                end
            end
            HALT: begin
                ifid_instr_d = 32'd0;
                ifid_pc4_d   = 32'd0;
                ifid_valid_d = 1'b0;
                // Only a redirect restarts fetching; it also acknowledges any fault.
                if (redirect) begin
                    state_d = FETCH;
                    pc_d    = redirect_tgt;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= BOOT;
            pc_q         <= PC_RESET;
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign im_read_en  = (state_q == FETCH) && !oor;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_fault = fault_q;

endmodule
